// File: rtl/nibble_pack_if.sv
// Nibble packer handshake bundle: nibble input stream and packed word output stream.
interface nibble_pack_if;
    logic        in_valid;
    logic [3:0]  in_nib;
    logic        flush;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_word;
    logic [2:0]  out_count;
    logic        out_ready;

    modport master (
        output in_valid, in_nib, flush, out_ready,
        input  in_ready, out_valid, out_word, out_count
    );

    modport slave (
        input  in_valid, in_nib, flush, out_ready,
        output in_ready, out_valid, out_word, out_count
    );
endinterface

// File: rtl/nibble_pack.sv
// Packs 4-bit nibbles LSB-first into 16-bit words, zero-padding flushed
// partial words, and buffers finished words in a small output FIFO.
module nibble_pack #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    nibble_pack_if.slave bus
);
    localparam int AW = (DEPTH > 2) ? 2 : 1;

    logic [15:0]   asm_q;
    logic [1:0]    idx;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [2:0]    occ;
    logic [15:0]   mem_word [DEPTH];
    logic [2:0]    mem_cnt  [DEPTH];

    logic          accept;
    logic          closing;
    logic          push;
    logic          pop;
    logic [15:0]   merged;
    logic [2:0]    close_cnt;

    // Ready depends only on registered occupancy, never on out_ready.
    assign bus.in_ready = occ < 3'(DEPTH);
    assign accept       = bus.in_valid && bus.in_ready;
    assign merged       = asm_q | ({12'h000, bus.in_nib} << {idx, 2'b00});
    assign closing      = bus.flush || (idx == 2'd3);
    assign push         = accept && closing;
    assign pop          = bus.out_valid && bus.out_ready;
    assign close_cnt    = {1'b0, idx} + 3'd1;

    assign bus.out_valid = occ != 3'd0;
    assign bus.out_word  = bus.out_valid ? mem_word[rd_ptr] : 16'h0000;
    assign bus.out_count = bus.out_valid ? mem_cnt[rd_ptr] : 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q <= 16'h0000;
            idx   <= 2'd0;
        end else if (accept) begin
            if (closing) begin
                asm_q <= 16'h0000;
                idx   <= 2'd0;
            end else begin
                asm_q <= merged;
                idx   <= idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr] <= merged;
            mem_cnt[wr_ptr]  <= close_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule
